// File: rtl/encoder8_3_if.sv
// Request/result bundle for the 8-to-3 priority encoder.
// Requests are active-low; results are registered active-high binary.
interface encoder8_3_if;
    logic A0;
    logic A1;
    logic A2;
    logic A3;
    logic A4;
    logic A5;
    logic A6;
    logic A7;
    logic Y0;
    logic Y1;
    logic Y2;
    logic valid;

    modport master (
        output A0, A1, A2, A3, A4, A5, A6, A7,
        input  Y0, Y1, Y2, valid
    );

    modport slave (
        input  A0, A1, A2, A3, A4, A5, A6, A7,
        output Y0, Y1, Y2, valid
    );
endinterface

// File: rtl/encoder8_3.sv
// 8-to-3 priority encoder, active-low requests, A7 highest priority.
// Index and any-request flag are registered: one clock of latency.
module encoder8_3 (
    input  logic          clk,
    input  logic          rst,
    encoder8_3_if.slave   bus
);
    logic [7:0] w_req;
    logic [2:0] w_idx;
    logic       w_any;
    logic [2:0] r_y;
    logic       r_valid;

    assign w_req = ~{bus.A7, bus.A6, bus.A5, bus.A4,
                     bus.A3, bus.A2, bus.A1, bus.A0};

    // Highest asserted index; ascending scan so the top line wins.
    always_comb begin
        w_idx = 3'd0;
        w_any = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (w_req[i]) begin
                w_idx = 3'(i);
                w_any = 1'b1;
            end
        end
    end

    // Register the code; reset overrides whatever is on the request lines.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_y     <= 3'd0;
            r_valid <= 1'b0;
        end else begin
            r_y     <= w_idx;
            r_valid <= w_any;
        end
    end

    assign bus.Y0    = r_y[0];
    assign bus.Y1    = r_y[1];
    assign bus.Y2    = r_y[2];
    assign bus.valid = r_valid;
endmodule

// File: tb/tb_encoder8_3.sv
// Scoreboard bench for encoder8_3: driver pushes expectations,
// monitor pops one per clock after the registering edge.
module tb_encoder8_3;
    logic clk;
    logic rst;

    typedef struct {
        logic [2:0] y;
        logic       v;
        string      name;
    } exp_t;

    exp_t q[$];
    int   checks;
    int   errors;

    encoder8_3_if bus ();

    encoder8_3 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: each edge registers one queued vector.
    initial begin
        exp_t       e;
        logic [2:0] got_y;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e     = q.pop_front();
                got_y = {bus.Y2, bus.Y1, bus.Y0};
                checks++;
                if (got_y !== e.y || bus.valid !== e.v) begin
                    errors++;
                    $display("FAIL %s: got Y=%b valid=%b, want Y=%b valid=%b",
                             e.name, got_y, bus.valid, e.y, e.v);
                end
            end
        end
    end

    task automatic step(input logic r, input logic [7:0] a,
                        input logic [2:0] ey, input logic ev,
                        input string nm);
        exp_t e;
        @(negedge clk);
        rst = r;
        {bus.A7, bus.A6, bus.A5, bus.A4,
         bus.A3, bus.A2, bus.A1, bus.A0} = a;
        e.y    = ey;
        e.v    = ev;
        e.name = nm;
        q.push_back(e);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        {bus.A7, bus.A6, bus.A5, bus.A4,
         bus.A3, bus.A2, bus.A1, bus.A0} = 8'h00;

        step(1'b1, 8'h00, 3'd0, 1'b0, "reset0");
        step(1'b1, 8'h00, 3'd0, 1'b0, "reset1");
        step(1'b0, 8'h00, 3'd7, 1'b1, "all_low");

        step(1'b0, 8'hFE, 3'd0, 1'b1, "walk0");
        step(1'b0, 8'hFD, 3'd1, 1'b1, "walk1");
        step(1'b0, 8'hFB, 3'd2, 1'b1, "walk2");
        step(1'b0, 8'hF7, 3'd3, 1'b1, "walk3");
        step(1'b0, 8'hEF, 3'd4, 1'b1, "walk4");
        step(1'b0, 8'hDF, 3'd5, 1'b1, "walk5");
        step(1'b0, 8'hBF, 3'd6, 1'b1, "walk6");
        step(1'b0, 8'h7F, 3'd7, 1'b1, "walk7");

        step(1'b0, 8'hFF, 3'd0, 1'b0, "none");
        step(1'b0, 8'hFE, 3'd0, 1'b1, "a0_only");

        step(1'b0, 8'hAA, 3'd6, 1'b1, "prio_AA");
        step(1'b0, 8'hF3, 3'd3, 1'b1, "prio_F3");

        step(1'b0, 8'h7F, 3'd7, 1'b1, "b2b_7F");
        step(1'b0, 8'hFD, 3'd1, 1'b1, "b2b_FD");
        step(1'b0, 8'hFF, 3'd0, 1'b0, "b2b_FF");

        step(1'b1, 8'hBF, 3'd0, 1'b0, "mid_rst");
        step(1'b0, 8'hBF, 3'd6, 1'b1, "post_rst");

        for (int i = 0; i < 20 && q.size() > 0; i++)
            @(posedge clk);
        #2;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, want 0", q.size());
        end
        if (checks != 20) begin
            errors++;
            $display("FAIL count: %0d checks, want 20", checks);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
